// File: rtl/fifo_uart_drain.sv
// fifo_uart_drain: drains 16-bit FIFO words to a UART as tagged byte frames,
// then closes the dump with an end frame carrying word count and checksum.
module fifo_uart_drain #(
  parameter logic [7:0] TAG_WORD = 8'hA5,
  parameter logic [7:0] TAG_END  = 8'h5A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_fifo_empty,
  output logic        o_fifo_ready_for_output,
  input  logic        i_fifo_output_valid,
  input  logic [15:0] i_fifo_output_data,
  input  logic        i_tx_ready,
  output logic        o_write_strobe,
  output logic [7:0]  o_write_data,
  output logic        o_busy,
  output logic        o_done
);
  typedef enum logic [3:0] {
    IDLE, CHECK, REQ, WAIT_DATA, TX_TAG, TX_MSB, TX_LSB,
    TX_END, TX_CNT_HI, TX_CNT_LO, TX_CSUM, DONE
  } state_t;
  state_t      r_state, w_next;
  logic [15:0] r_word, r_count;
  logic [7:0]  r_csum, r_data, w_byte;
  logic        r_strobe, r_rd, r_busy, r_done, w_tx;
  // tx_ready lags the strobe by a cycle, so the cycle after a strobe is skipped
  assign w_tx = i_tx_ready && !r_strobe;
  assign o_fifo_ready_for_output = r_rd;
  assign o_write_strobe = r_strobe;
  assign o_write_data = r_data;
  assign o_busy = r_busy;
  assign o_done = r_done;
  always_comb begin
    w_byte = 8'h00;
    w_next = r_state;
    case (r_state)
      TX_TAG:    begin w_byte = TAG_WORD;       w_next = TX_MSB;    end
      TX_MSB:    begin w_byte = r_word[15:8];   w_next = TX_LSB;    end
      TX_LSB:    begin w_byte = r_word[7:0];    w_next = CHECK;     end
      TX_END:    begin w_byte = TAG_END;        w_next = TX_CNT_HI; end
      TX_CNT_HI: begin w_byte = r_count[15:8];  w_next = TX_CNT_LO; end
      TX_CNT_LO: begin w_byte = r_count[7:0];   w_next = TX_CSUM;   end
      TX_CSUM:   begin w_byte = r_csum;         w_next = DONE;      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_word   <= 16'h0000;
      r_count  <= 16'h0000;
      r_csum   <= 8'h00;
      r_data   <= 8'h00;
      r_strobe <= 1'b0;
      r_rd     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_data   <= 8'h00;
      r_rd     <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        IDLE: if (i_start) begin
          r_state <= CHECK;
          r_busy  <= 1'b1;
          r_count <= 16'h0000;
          r_csum  <= 8'h00;
        end
        CHECK: begin
          r_state <= i_fifo_empty ? TX_END : REQ;
          r_rd    <= !i_fifo_empty;
        end
        REQ: r_state <= WAIT_DATA;
        WAIT_DATA: if (i_fifo_output_valid) begin
          r_word  <= i_fifo_output_data;
          r_state <= TX_TAG;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: if (w_tx) begin
          r_strobe <= 1'b1;
          r_data   <= w_byte;
          r_state  <= w_next;
          r_done   <= (r_state == TX_CSUM);
          if (r_state inside {TX_MSB, TX_LSB}) r_csum <= r_csum ^ w_byte;
          if (r_state == TX_LSB && r_count != 16'hFFFF) r_count <= r_count + 16'd1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_uart_drain.sv
// tb_fifo_uart_drain: scoreboard bench; expected UART bytes are queued by the
// stimulus and popped by a monitor on every write strobe.
module tb_fifo_uart_drain;
  logic        clk = 0;
  logic        reset = 1;
  logic        i_start = 0;
  logic        i_fifo_empty = 1;
  logic        o_fifo_ready_for_output;
  logic        i_fifo_output_valid = 0;
  logic [15:0] i_fifo_output_data = 0;
  logic        i_tx_ready = 1;
  logic        o_write_strobe;
  logic [7:0]  o_write_data;
  logic        o_busy;
  logic        o_done;

  fifo_uart_drain dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_fifo_empty(i_fifo_empty),
    .o_fifo_ready_for_output(o_fifo_ready_for_output),
    .i_fifo_output_valid(i_fifo_output_valid), .i_fifo_output_data(i_fifo_output_data),
    .i_tx_ready(i_tx_ready), .o_write_strobe(o_write_strobe), .o_write_data(o_write_data),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, last_strb = -10, strb_cnt = 0, done_cnt = 0, rd_cnt = 0, fifo_delay = 1;
  logic [7:0]  exp_q[$];
  logic [15:0] fifo_q[$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", n, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // monitor: every strobed byte must match the head of the scoreboard
  always @(negedge clk) if (!reset) begin
    if (o_write_strobe) begin
      if (exp_q.size() == 0) chk("unexpected byte", {24'h0, o_write_data}, 32'hFFFF_FFFF);
      else chk("byte", {24'h0, o_write_data}, {24'h0, exp_q.pop_front()});
      chk("strobe spacing ok", 32'(cyc - last_strb >= 2), 1);
      last_strb = cyc;
      strb_cnt++;
    end else chk("idle data", {24'h0, o_write_data}, 0);
    if (o_done) begin
      chk("bytes left at done", exp_q.size(), 0);
      done_cnt++;
    end
  end

  always @(negedge clk) i_fifo_empty = (fifo_q.size() == 0);

  // FIFO model: answers each read request after fifo_delay cycles
  initial forever begin
    @(negedge clk);
    if (o_fifo_ready_for_output && !reset) begin
      rd_cnt++;
      chk("read from non-empty", fifo_q.size() != 0, 1);
      i_fifo_output_data = fifo_q.size() != 0 ? fifo_q.pop_front() : 16'h0;
      repeat (fifo_delay) @(negedge clk);
      i_fifo_output_valid = 1;
      @(negedge clk);
      i_fifo_output_valid = 0;
    end
  end

  task automatic pulse_start();
    @(negedge clk); i_start = 1;
    @(negedge clk); i_start = 0;
  endtask

  task automatic wait_done(input string n);
    int d0, k;
    d0 = done_cnt; k = 0;
    while (done_cnt == d0 && k < 1000) begin @(posedge clk); #2; k++; end
    chk({n, " done seen"}, done_cnt - d0, 1);
    chk({n, " scoreboard empty"}, exp_q.size(), 0);
    repeat (2) @(posedge clk); #2;
    chk({n, " idle after done"}, {31'h0, o_busy}, 0);
  endtask

  task automatic wait_strb(input int target);
    int k;
    k = 0;
    while (strb_cnt < target && k < 1000) begin @(posedge clk); #2; k++; end
    chk("strobe wait in time", 32'(strb_cnt >= target), 1);
  endtask

  task automatic chk_zero(input string n);
    chk(n, {27'h0, o_write_strobe, o_fifo_ready_for_output, o_busy, o_done, 1'b0} | {24'h0, o_write_data}, 0);
  endtask

  initial begin
    int s0, r0;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset outputs");
    @(negedge clk) reset = 0;

    // empty FIFO: only the end frame
    exp_q = {8'h5A, 8'h00, 8'h00, 8'h00};
    r0 = rd_cnt;
    pulse_start();
    chk("busy after start", {31'h0, o_busy}, 1);
    wait_done("empty");
    chk("empty no read", rd_cnt - r0, 0);

    // two words
    fifo_q = {16'h1234, 16'hABCD};
    exp_q = {8'hA5, 8'h12, 8'h34, 8'hA5, 8'hAB, 8'hCD, 8'h5A, 8'h00, 8'h02, 8'h40};
    r0 = rd_cnt;
    pulse_start();
    wait_done("two words");
    chk("two words reads", rd_cnt - r0, 2);

    // tx_ready stall mid-frame
    fifo_q = {16'hBEEF};
    exp_q = {8'hA5, 8'hBE, 8'hEF, 8'h5A, 8'h00, 8'h01, 8'h51};
    s0 = strb_cnt;
    pulse_start();
    wait_strb(s0 + 1);
    i_tx_ready = 0;
    s0 = strb_cnt;
    repeat (20) @(posedge clk);
    #2 chk("no strobe while stalled", strb_cnt - s0, 0);
    i_tx_ready = 1;
    wait_done("stall");

    // slow FIFO and start while busy
    fifo_delay = 5;
    fifo_q = {16'h0042};
    exp_q = {8'hA5, 8'h00, 8'h42, 8'h5A, 8'h00, 8'h01, 8'h42};
    r0 = rd_cnt; s0 = done_cnt;
    pulse_start();
    @(negedge clk); i_start = 1;
    repeat (3) @(negedge clk);
    i_start = 0;
    wait_done("slow fifo");
    chk("slow fifo one read", rd_cnt - r0, 1);
    repeat (20) @(posedge clk);
    #2 chk("busy start ignored", done_cnt - s0, 1);
    fifo_delay = 1;

    // reset after MSB strobe abandons the frame
    fifo_q = {16'h1111, 16'h2233};
    exp_q = {8'hA5, 8'h11};
    s0 = strb_cnt;
    pulse_start();
    wait_strb(s0 + 2);
    reset = 1;
    @(posedge clk);
    #1 chk_zero("mid-frame reset outputs");
    @(negedge clk) reset = 0;
    chk("abandoned frame consumed", exp_q.size(), 0);
    exp_q = {8'hA5, 8'h22, 8'h33, 8'h5A, 8'h00, 8'h01, 8'h11};
    pulse_start();
    wait_done("after reset");

    // word arrives while last LSB is pending
    fifo_q = {16'h00FF};
    exp_q = {8'hA5, 8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h5A, 8'h00, 8'h02, 8'hFE};
    s0 = strb_cnt;
    pulse_start();
    wait_strb(s0 + 2);
    i_tx_ready = 0;
    fifo_q.push_back(16'h0100);
    repeat (3) @(posedge clk);
    i_tx_ready = 1;
    wait_done("late push");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
